// File: rtl/memory_port_arbiter_pkg.sv
// Shared constants and state encoding for the game-memory arbiter.
// Imported by the arbiter top and reusable by other memory clients.
package memory_port_arbiter_pkg;

    localparam int MEM_DATA_W = 48;
    localparam int MEM_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/memory_port_arbiter_rr_picker.sv
// Round-robin picker: finds the first asserted request after last_grant.
// Ports: req, last_grant in; winner index, any_req out. Combinational.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      winner,
    output logic               any_req
);

    logic [IW-1:0] pos;

    // Walk from the farthest offset to the nearest, so the nearest
    // asserted request after last_grant overwrites the others.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        pos     = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            pos = IW'((int'(last_grant) + off) % NUM_REQ);
            if (req[pos]) begin
                winner  = pos;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter for the single-port game memory with a timed
// access window. Ports: clock, resetn; per-requester req/req_we/
// req_addr/req_wdata; memory mem_addr/mem_wdata/mem_we/mem_rdata;
// status grant, ack, rdata, busy.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_we,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    arb_state_t    state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] owner;
    logic [IW-1:0] winner;
    logic          any_req;
    logic          lat_we;
    logic [CW-1:0] cnt;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    function automatic logic [NUM_REQ-1:0] onehot(
        input logic [IW-1:0] i
    );
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= LAST_RST;
            owner      <= '0;
            lat_we     <= 1'b0;
            cnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            grant      <= '0;
            ack        <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ACCESS;
                        owner      <= winner;
                        last_grant <= winner;
                        lat_we     <= req_we[winner];
                        mem_we     <= req_we[winner];
                        mem_addr   <=
                            req_addr[int'(winner)*ADDR_W +: ADDR_W];
                        mem_wdata  <=
                            req_wdata[int'(winner)*DATA_W +: DATA_W];
                        grant      <= onehot(winner);
                        busy       <= 1'b1;
                        cnt        <= '0;
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        state  <= ACK;
                        mem_we <= 1'b0;
                        ack    <= onehot(owner);
                        if (!lat_we) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    ack   <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: vector table,
// ack scoreboard, and sequences for reset abort, contention, withdraw.
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int DW = 48;
    localparam int AW = 5;
    localparam int WC = 3;

    logic             clock     = 1'b0;
    logic             resetn    = 1'b0;
    logic [NR-1:0]    req       = '0;
    logic [NR-1:0]    req_we    = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [DW-1:0]    mem_rdata;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_we;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    ack;
    logic [DW-1:0]    rdata;
    logic             busy;

    memory_port_arbiter #(
        .NUM_REQ     (NR),
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .WAIT_CYCLES (WC)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .grant     (grant),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [32];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= '0;
        mem[5] <= 48'h0000_DEAD_BEEF;
    end

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign mem_rdata = mem[mem_addr];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        bit          chk;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];

    always @(negedge clock) begin : mon
        exp_t e;
        logic [NR-1:0] oh;
        if (ack !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'(ack), 64'd0);
            end else begin
                e = sb.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                check("ack_onehot", 64'(ack), 64'(oh));
                if (e.chk) check("rdata", 64'(rdata), 64'(e.rdata));
            end
        end
    end

    typedef struct {
        int            idx;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic push_exp(input int idx, input bit chk,
                            input logic [DW-1:0] rd);
        exp_t e;
        e.idx = idx;
        e.chk = chk;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic do_access(input vec_t v);
        int cyc;
        int wr;
        int gc;
        bit got;
        logic [NR-1:0] oh;
        oh = '0;
        oh[v.idx] = 1'b1;
        push_exp(v.idx, !v.we, v.exp_rdata);
        req_we[v.idx] = v.we;
        req_addr[v.idx*AW +: AW] = v.addr;
        req_wdata[v.idx*DW +: DW] = v.wdata;
        req[v.idx] = 1'b1;
        cyc = 0;
        wr = 0;
        gc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (mem_we) begin
                wr++;
                check("wr_addr", 64'(mem_addr), 64'(v.addr));
            end
            if (grant == oh) gc++;
            if (ack != '0) got = 1;
        end
        req[v.idx] = 1'b0;
        check("ack_latency", 64'(cyc), 64'(WC + 1));
        check("we_cycles", 64'(wr), v.we ? 64'(WC) : 64'd0);
        check("grant_cycles", 64'(gc), 64'(WC + 1));
        @(negedge clock);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int c;
        int k;
        int ack_t[4];
        bit got;

        vecs[0] = '{1, 1'b0, 5'd5,  48'h0, 48'h0000_DEAD_BEEF};
        vecs[1] = '{0, 1'b1, 5'd3,  48'h1234_5678_9ABC, 48'h0};
        vecs[2] = '{1, 1'b0, 5'd3,  48'h0, 48'h1234_5678_9ABC};
        vecs[3] = '{0, 1'b1, 5'd31, 48'hFFFF_FFFF_FFFF, 48'h0};
        vecs[4] = '{0, 1'b0, 5'd31, 48'h0, 48'hFFFF_FFFF_FFFF};
        vecs[5] = '{1, 1'b1, 5'd0,  48'h0000_0000_0001, 48'h0};
        vecs[6] = '{0, 1'b0, 5'd0,  48'h0, 48'h0000_0000_0001};
        vecs[7] = '{1, 1'b0, 5'd7,  48'h0, 48'h0};

        repeat (2) @(negedge clock);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        check("noreq_busy", 64'(busy), 64'd0);
        check("noreq_we", 64'(mem_we), 64'd0);

        foreach (vecs[i]) do_access(vecs[i]);

        // Abort a write with reset in its second ACCESS cycle.
        req_we[0] = 1'b1;
        req_addr[0 +: AW] = 5'd9;
        req_wdata[0 +: DW] = 48'hABCD;
        req[0] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("abort_we_pre", 64'(mem_we), 64'd1);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_we", 64'(mem_we), 64'd0);
        check("abort_grant", 64'(grant), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ack", 64'(ack), 64'd0);

        // Contention straight out of reset: 0 must win first.
        req_we = '0;
        req_addr[0 +: AW] = 5'd5;
        req_addr[AW +: AW] = 5'd3;
        req = 2'b11;
        push_exp(0, 1'b1, 48'h0000_DEAD_BEEF);
        push_exp(1, 1'b1, 48'h1234_5678_9ABC);
        push_exp(0, 1'b1, 48'h0000_DEAD_BEEF);
        push_exp(1, 1'b1, 48'h1234_5678_9ABC);
        @(negedge clock);
        resetn = 1'b1;
        c = 0;
        k = 0;
        while (k < 4 && c < 40) begin
            @(negedge clock);
            c++;
            if (ack != '0) begin
                ack_t[k] = c;
                k++;
            end
        end
        req = '0;
        check("cont_acks", 64'(k), 64'd4);
        if (k == 4) begin
            check("cont_first", 64'(ack_t[0]), 64'(WC + 1));
            for (int i = 1; i < 4; i++) begin
                check("cont_spacing", 64'(ack_t[i] - ack_t[i-1]),
                      64'(WC + 2));
            end
        end
        @(negedge clock);

        // Request withdrawn and address changed after grant.
        push_exp(1, 1'b1, 48'h0000_DEAD_BEEF);
        req_we[1] = 1'b0;
        req_addr[AW +: AW] = 5'd5;
        req[1] = 1'b1;
        @(negedge clock);
        check("wd_grant", 64'(grant), 64'd2);
        req[1] = 1'b0;
        req_addr[AW +: AW] = 5'd10;
        c = 0;
        got = 0;
        while (!got && c < 10) begin
            @(negedge clock);
            c++;
            if (ack != '0) got = 1;
            else check("wd_hold_addr", 64'(mem_addr), 64'd5);
        end
        check("wd_ack_seen", 64'(got), 64'd1);
        repeat (3) @(negedge clock);
        check("end_busy", 64'(busy), 64'd0);
        check("end_we", 64'(mem_we), 64'd0);
        check("end_addr_hold", 64'(mem_addr), 64'd5);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
